// File: rtl/uart_pkg.sv
// Shared types and constants for the Hamming(7,4) UART link.
// Frame is start + FRAME_DATA_BITS data bits (LSB first) + stop.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } tx_state_t;

   localparam int   FRAME_DATA_BITS = 7;
   localparam logic LINE_IDLE       = 1'b1;

endpackage

// File: rtl/hamming74_encoder.sv
// Hamming(7,4) encoder: parity bits at codeword positions 0, 1 and 3.
// Purely combinational, no backpressure.
module hamming74_encoder (
   input  logic [3:0] d,
   output logic [6:0] c
);

   assign c[0] = d[0] ^ d[1] ^ d[3];
   assign c[1] = d[0] ^ d[2] ^ d[3];
   assign c[2] = d[0];
   assign c[3] = d[1] ^ d[2] ^ d[3];
   assign c[4] = d[1];
   assign c[5] = d[2];
   assign c[6] = d[3];

endmodule

// File: rtl/uart_hamming_tx.sv
// UART frame transmitter, optional Hamming(7,4) encode under UART_TX_HAMMING_EN.
// Latency: tx falls 1 cycle after accept; frame lasts 9*CLKS_PER_BIT enabled cycles.
// Backpressure: ready_out only in IDLE; valid_in while busy is ignored, not queued.
module uart_hamming_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [6:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int            CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST = 3'(FRAME_DATA_BITS - 1);

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [6:0]       shift_reg;
   logic [6:0]       codeword;
   logic             tx_q;
   logic             done_q;
   logic             cnt_wrap;

`ifdef UART_TX_HAMMING_EN
   logic unused_msbs;
   assign unused_msbs = ^data_in[6:4];

   hamming74_encoder u_enc (
      .d (data_in[3:0]),
      .c (codeword)
   );
`else
   assign codeword = data_in;
`endif

   assign cnt_wrap  = (clk_cnt == CNT_LAST);
   assign ready_out = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign tx        = tx_q;
   assign done      = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            IDLE:    if (valid_in) state_d = START;
            START:   if (cnt_wrap) state_d = DATA;
            DATA:    if (cnt_wrap && bit_cnt == BIT_LAST) state_d = STOP;
            STOP:    if (cnt_wrap) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // tx is loaded with the level of the state being entered, so it is glitch-free
   // and never depends combinationally on data_in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx_q      <= LINE_IDLE;
         done_q    <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               tx_q    <= LINE_IDLE;
               if (valid_in) begin
                  shift_reg <= codeword;
                  tx_q      <= ~LINE_IDLE;
               end
            end
            START: begin
               clk_cnt <= cnt_wrap ? '0 : clk_cnt + 1'b1;
               if (cnt_wrap) tx_q <= shift_reg[0];
            end
            DATA: begin
               clk_cnt <= cnt_wrap ? '0 : clk_cnt + 1'b1;
               if (cnt_wrap) begin
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= bit_cnt + 1'b1;
                  tx_q      <= (bit_cnt == BIT_LAST) ? LINE_IDLE : shift_reg[1];
               end
            end
            STOP: begin
               clk_cnt <= cnt_wrap ? '0 : clk_cnt + 1'b1;
               tx_q    <= LINE_IDLE;
               if (cnt_wrap) done_q <= 1'b1;
            end
            default: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               tx_q    <= LINE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_hamming_tx.sv
// Directed bench for uart_hamming_tx; expected codewords follow UART_TX_HAMMING_EN.
module tb_uart_hamming_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [6:0] data_in;
   logic       valid_in;
   logic       ready_out;
   logic       tx;
   logic       busy;
   logic       done;

   int compared = 0;
   int mism     = 0;

   always #5 clk = ~clk;

   uart_hamming_tx #(.CLKS_PER_BIT(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .tx        (tx),
      .busy      (busy),
      .done      (done)
   );

   // Hand-computed codewords for the words used below.
   function automatic logic [6:0] cw_of(input logic [6:0] w);
`ifdef UART_TX_HAMMING_EN
      case (w)
         7'h0B:   return 7'h55;
         7'h0F:   return 7'h7F;
         7'h70:   return 7'h00;
         7'h2A:   return 7'h52;
         7'h01:   return 7'h07;
         7'h7E:   return 7'h78;
         default: return 7'hxx;
      endcase
`else
      return w;
`endif
   endfunction

   // Expected line level in enabled-cycle e (1-based) after the accept edge.
   function automatic logic exp_bit(input logic [6:0] cw, input int e);
      if (e <= 8)  return 1'b0;
      if (e <= 64) return cw[(e - 9) / 8];
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while idle; returns at the negedge of cycle 1 after accept.
   task automatic start(input logic [6:0] w, input logic keep);
      chk("ready_before_accept", ready_out, 1);
      data_in  = w;
      valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep) valid_in = 1'b0;
   endtask

   // Checks one frame cycle by cycle; ena is dropped for cycles dis_lo..dis_hi and
   // valid_in is pulsed on cycle pulse_c. Returns at the negedge of the done cycle.
   task automatic check_frame(input string tag, input logic [6:0] cw,
                              input int dis_lo, input int dis_hi, input int pulse_c);
      int e = 1;
      int c = 1;
      while (e <= 72 && c < 200) begin
         ena = !(c >= dis_lo && c <= dis_hi);
         if (pulse_c != 0) valid_in = (c == pulse_c);
         chk({tag, "_tx"}, tx, exp_bit(cw, e));
         chk({tag, "_busy"}, busy, 1);
         chk({tag, "_done_early"}, done, 0);
         @(posedge clk);
         if (ena) e++;
         c++;
         @(negedge clk);
      end
      ena = 1'b1;
      if (pulse_c != 0) valid_in = 1'b0;
      chk({tag, "_cycle_budget"}, c, 73 + ((dis_lo != 0) ? dis_hi - dis_lo + 1 : 0));
      chk({tag, "_done"}, done, 1);
      chk({tag, "_ready_end"}, ready_out, 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_tx_gap"}, tx, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      ena      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", ready_out, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      start(7'h0B, 1'b0);
      check_frame("w0B", cw_of(7'h0B), 0, 0, 0);
      start(7'h0F, 1'b0);
      check_frame("w0F", cw_of(7'h0F), 0, 0, 0);
      start(7'h70, 1'b0);
      check_frame("w70", cw_of(7'h70), 0, 0, 0);
      start(7'h2A, 1'b0);
      check_frame("w2A", cw_of(7'h2A), 0, 0, 0);

      // Back-to-back with valid_in held: second accept lands on the done cycle.
      start(7'h01, 1'b1);
      data_in = 7'h7E;
      check_frame("b2b_1", cw_of(7'h01), 0, 0, 0);
      chk("b2b_valid_held", valid_in, 1);
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      check_frame("b2b_2", cw_of(7'h7E), 0, 0, 0);

      // ena dropped for 5 cycles inside data bit 3; a valid pulse while busy is dropped.
      start(7'h0B, 1'b0);
      check_frame("ena", cw_of(7'h0B), 35, 39, 10);
      repeat (3) begin
         @(negedge clk);
         chk("not_queued_busy", busy, 0);
         chk("not_queued_tx", tx, 1);
      end

      // Reset mid-DATA abandons the frame immediately.
      start(7'h2A, 1'b0);
      repeat (30) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_ready", ready_out, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start(7'h2A, 1'b0);
      check_frame("post_rst", cw_of(7'h2A), 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule

// File: doc/uart_hamming_tx.md
# uart_hamming_tx

Serial transmitter for the Hamming(7,4) UART link. It accepts a data word over a valid/ready handshake and optionally Hamming(7,4)-encodes it. It then serialises the 7-bit codeword as one frame: start bit, 7 data bits LSB first, stop bit. It is the transmit-side counterpart of the link's UART receiver and drives the TT output pin that feeds the remote receive line.

## Interface
- CLKS_PER_BIT, 8: clock cycles per bit period; legal range 2..255.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  clock enable, active high. When low, all state, counters and outputs are frozen.
- data_in  in  7  payload. With encoding enabled only [3:0] is used; otherwise [6:0] is sent verbatim.
- valid_in  in  1  payload valid.
- ready_out  out  1  high when the block can accept a word; decoded from state == IDLE.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP.
- **IDLE:** tx=1, ready_out=1.
  - Accept when ena & valid_in & ready_out at a clk edge.
  - On accept: latch the codeword into shift_reg[6:0], clear bit_cnt and clk_cnt, go to START.
- **START:** tx=0 for CLKS_PER_BIT enabled cycles, then go to DATA.
- **DATA:** tx=shift_reg[0].
  - Each time clk_cnt reaches CLKS_PER_BIT-1: shift_reg >>= 1, bit_cnt++, clk_cnt=0.
  - When bit_cnt==6 completes its period, go to STOP.
  - Exactly 7 data bits are sent.
- **STOP:** tx=1 for CLKS_PER_BIT cycles. On the final cycle: done=1 (registered, one cycle), go to IDLE.
- clk_cnt: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps in every non-IDLE state.
- tx is a registered output with no combinational path from data_in.
- valid_in while busy is ignored; it is not queued, and the sender must hold valid_in until accepted.
- With ena low mid-frame, the current bit is stretched by the number of disabled cycles and tx holds its level.
- Illegal state encoding recovers to IDLE with tx=1.
- rst_n asserted mid-frame: immediate return to IDLE; tx=1, busy=0, done=0, shift_reg cleared. A partial frame is abandoned.
- Reset values: tx=1, ready_out=1, busy=0, done=0.

## Timing
- Accept edge to tx falling: 1 cycle; tx goes low in the cycle after acceptance.
- Frame length: 9*CLKS_PER_BIT enabled cycles (72 at the default).
- done is high in the cycle after the last stop-bit cycle, coincident with ready_out=1.
- Back-to-back: with valid_in held, the next word is accepted on the first IDLE cycle. The minimum gap between frames is 1 idle cycle of tx=1 beyond the stop bit. Inter-frame period is 9*CLKS_PER_BIT+1.
- busy rises 1 cycle after acceptance and falls together with the done pulse.

## Configuration
- Macro: UART_TX_HAMMING_EN.
- **Defined:** the codeword is computed from the nibble d=data_in[3:0]:
  - c[0]=d0^d1^d3
  - c[1]=d0^d2^d3
  - c[2]=d0
  - c[3]=d1^d2^d3
  - c[4]=d1
  - c[5]=d2
  - c[6]=d3
  - data_in[6:4] is ignored.
- **Undefined:** codeword = data_in[6:0] and no encoder is instantiated. Frame timing is identical in both builds.

## Structure
- Package uart_pkg holds:
  - state enum tx_state_t (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11);
  - FRAME_DATA_BITS=7;
  - the line idle level LINE_IDLE=1'b1.
- Sub-module hamming74_encoder: purely combinational, 4-bit d in, 7-bit c out. It is instantiated only under UART_TX_HAMMING_EN.
- The top holds the FSM, clk_cnt, bit_cnt, shift_reg, and the tx/done registers.

## Test plan
- Reset: assert rst_n low mid-DATA → tx=1, ready_out=1, busy=0, done=0 immediately. After release, the first frame is clean.
- Encoding on: data_in=7'h0B (nibble 1011), CLKS_PER_BIT=8.
  - tx low for 8 cycles, then bits 1,0,1,0,1,0,1 (codeword 7'h55) LSB first, 8 cycles each, then high for 8 cycles.
  - done pulses at cycle 73 after accept.
- Encoding on, nibble 4'hF → codeword 7'h7F. Nibble 4'h0 → 7'h00, with data_in[6:4]=3'b111 ignored.
- Encoding off: data_in=7'h2A → serial bits 0,1,0,1,0,1,0 after the start bit.
- Back-to-back: valid_in held high with words 7'h01 then 7'h7E → both frames sent, exactly one idle-high cycle between the stop bit and the second start bit, and two done pulses 73 cycles apart.
- ena gating: drop ena for 5 cycles during data bit 3 → bit 3 lasts 13 cycles and all other bits last 8. valid_in pulsed while busy is not accepted.
